rr_hold_arbiter: RTL
====================

Name: rr_hold_arbiter

Overview:
- Sequential round-robin arbiter that shares one resource between PORTS requesters, with registered one-hot grants.
- A winner keeps the grant for as long as it holds its request (transaction lock).
- Priority rotates on every release, so a continuously requesting port is never starved.
- Drop-in sequential companion to the team's combinational fixed-priority arbiter; same req/gnt bit ordering (bit 0 = port 0).

Parameters:
- PORTS, 4, number of requesters; legal range 2..32.
- MAX_HOLD, 16, maximum consecutive grant cycles per winner; used only when HOLD_LIMIT_EN is defined; legal range >= 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- req  input  PORTS  request per port; bit i = port i.
- gnt  output  PORTS  registered one-hot grant; all-zero when no grant.
- gnt_vld  output  1  high whenever gnt is non-zero.
- gnt_id  output  ID_W  binary index of the granted port; ID_W = $clog2(PORTS).
- hold_expired  output  1  one-cycle pulse on a forced rotation; tied 0 without HOLD_LIMIT_EN.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high; ports are named clk and rst.
- Reset (async assert, released synchronously by the system):
  - gnt=0, gnt_vld=0, gnt_id=0, hold_expired=0.
  - State IDLE, rotation pointer ptr=0, hold counter=0.
- Search rule: the winner is the first port with req=1, scanning circularly ptr, ptr+1, ..., ptr+PORTS-1 (mod PORTS).
- IDLE:
  - If req!=0, the next edge moves to GRANT and registers the winner in gnt/gnt_id, with gnt_vld=1.
  - Latency: req asserted in cycle N gives gnt in cycle N+1.
  - If req==0, stay in IDLE.
- GRANT, holder h=gnt_id:
  - If req[h]=1, hold: gnt is unchanged; other requests are ignored.
  - If req[h]=0 (release), ptr <= (h+1) mod PORTS at the same edge.
  - On release with other requests present, the next winner is granted at that same edge (search from h+1), with no idle bubble.
  - On release with no requests, go to IDLE; gnt=0 on the next cycle.
- The holder sees gnt for one cycle after dropping req (registered release). Requesters must not treat that cycle as a new grant.
- Re-request by the just-released port is served only after the ports after it in circular order.
- Request changes on non-holding ports while in GRANT have no effect until release.
- gnt is always one-hot or zero; gnt_id always matches gnt; gnt_vld == |gnt.
- Reset mid-grant: outputs clear immediately (asynchronous) and ptr returns to 0. The first post-reset arbitration starts from port 0.

Optional Feature:
- Macro: HOLD_LIMIT_EN.
- Defined:
  - Hold counter clears on every new grant and increments on each cycle gnt_vld=1 with req[h]=1.
  - When the counter equals MAX_HOLD-1 and req[h] is still 1, the next edge forces a release: ptr <= h+1, next winner searched from h+1, and hold_expired=1 for exactly that one cycle.
  - If h is the only requester, it is re-granted: gnt unchanged, counter restarts at 0, hold_expired still pulses.
  - A normal release on the limit cycle takes precedence, so hold_expired=0.
- Not defined: no counter logic; hold is unbounded; hold_expired is constant 0; MAX_HOLD is ignored.

Test Plan:
- Reset: rst=1 while req=4'b1111 -> gnt=0, gnt_vld=0, gnt_id=0 immediately and throughout reset; after release, first grant is gnt=4'b0001 one cycle later.
- Hold/handoff: from IDLE with ptr=0, req=4'b1010 -> next cycle gnt=4'b0010, id=1. Hold req[1] for 5 cycles -> gnt stable. Drop req[1] -> next edge gnt=4'b1000, id=3, no bubble, ptr=2.
- Fairness: req=4'b1111, each holder drops its req for one cycle after 2 granted cycles, then reasserts -> grant order 0,1,2,3,0,1; every port is granted once per 4 transactions.
- Idle return: only req[2]=1, granted, then dropped with req=0 -> gnt=4'b0100 for one more cycle, then gnt=0 and gnt_vld=0; next req[0]=1 is granted with ptr=3 -> gnt=4'b0001.
- Async reset mid-grant: assert rst between edges while gnt=4'b0100 -> gnt=0 within the same cycle; with req=4'b0110 after release -> gnt=4'b0010, since ptr=0.
- HOLD_LIMIT_EN with MAX_HOLD=4: req=4'b0011 held constantly -> port 0 granted 4 cycles, then port 1 for 4 cycles, then port 0, with a hold_expired pulse at each switch. req=4'b0001 only -> gnt stays 4'b0001 and hold_expired pulses every 4 cycles.

Source files
------------

// File: rtl/rr_hold_arbiter.sv
// rtl/rr_hold_arbiter.sv - round-robin arbiter with registered one-hot grants and transaction lock
// Define HOLD_LIMIT_EN to force rotation after MAX_HOLD consecutive grant cycles.
module rr_hold_arbiter #(
    parameter int PORTS = 4,
    parameter int MAX_HOLD = 16,
    localparam int ID_W = $clog2(PORTS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PORTS-1:0] req,
    output logic [PORTS-1:0] gnt,
    output logic             gnt_vld,
    output logic [ID_W-1:0]  gnt_id,
    output logic             hold_expired
);

    if (PORTS < 2 || PORTS > 32) begin : g_bad_ports
        $error("rr_hold_arbiter: PORTS must be within 2..32");
    end
    if (MAX_HOLD < 2) begin : g_bad_hold
        $error("rr_hold_arbiter: MAX_HOLD must be at least 2");
    end

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  ptr_nxt;
    logic [PORTS-1:0] gnt_q;
    logic [PORTS-1:0] gnt_nxt;
    logic [ID_W-1:0]  gnt_id_q;
    logic [ID_W-1:0]  id_nxt;
    logic [ID_W-1:0]  holder;
    logic [ID_W-1:0]  after_holder;
    logic [ID_W-1:0]  pick_ptr;
    logic [ID_W-1:0]  pick_after;
    logic             holder_req;

    // First requester at or after start, wrapping modulo PORTS.
    function automatic logic [ID_W-1:0] rr_pick(input logic [PORTS-1:0] r,
                                                input logic [ID_W-1:0]  start);
        logic [ID_W-1:0] pick;
        logic [ID_W-1:0] cand;
        logic            found;
        int              idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < PORTS; k++) begin
            idx = int'(start) + k;
            if (idx >= PORTS) idx -= PORTS;
            cand = ID_W'(idx);
            if (!found && r[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        return pick;
    endfunction

    function automatic logic [PORTS-1:0] onehot(input logic [ID_W-1:0] id);
        return {{(PORTS-1){1'b0}}, 1'b1} << id;
    endfunction

    assign holder       = gnt_id_q;
    assign holder_req   = req[holder];
    assign after_holder = (holder == ID_W'(PORTS-1)) ? '0 : holder + 1'b1;
    assign pick_ptr     = rr_pick(req, ptr);
    assign pick_after   = rr_pick(req, after_holder);

`ifdef HOLD_LIMIT_EN
    localparam int CNT_W = $clog2(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             expired_q;
    logic             expired_nxt;
    logic             limit_hit;

    assign limit_hit = (hold_cnt == CNT_LAST);
`endif

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        gnt_nxt   = gnt_q;
        id_nxt    = gnt_id_q;
`ifdef HOLD_LIMIT_EN
        cnt_nxt     = hold_cnt;
        expired_nxt = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt = GRANT;
                    gnt_nxt   = onehot(pick_ptr);
                    id_nxt    = pick_ptr;
`ifdef HOLD_LIMIT_EN
                    cnt_nxt = '0;
`endif
                end
            end
            GRANT: begin
                // Release hands over at the same edge when anyone else is waiting.
                if (!holder_req) begin
                    ptr_nxt = after_holder;
                    if (|req) begin
                        gnt_nxt = onehot(pick_after);
                        id_nxt  = pick_after;
`ifdef HOLD_LIMIT_EN
                        cnt_nxt = '0;
`endif
                    end else begin
                        state_nxt = IDLE;
                        gnt_nxt   = '0;
                        id_nxt    = '0;
                    end
                end
`ifdef HOLD_LIMIT_EN
                else if (limit_hit) begin
                    // Holder is still in the search set, so a lone requester is re-granted.
                    ptr_nxt     = after_holder;
                    gnt_nxt     = onehot(pick_after);
                    id_nxt      = pick_after;
                    cnt_nxt     = '0;
                    expired_nxt = 1'b1;
                end else begin
                    cnt_nxt = hold_cnt + 1'b1;
                end
`endif
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            gnt_q    <= '0;
            gnt_id_q <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            gnt_q    <= gnt_nxt;
            gnt_id_q <= id_nxt;
        end
    end

`ifdef HOLD_LIMIT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt  <= '0;
            expired_q <= 1'b0;
        end else begin
            hold_cnt  <= cnt_nxt;
            expired_q <= expired_nxt;
        end
    end

    assign hold_expired = expired_q;
`else
    assign hold_expired = 1'b0;
`endif

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign gnt_vld = |gnt_q;

    a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
    a_gnt_id:     assert property (@(posedge clk) disable iff (rst) (gnt_q == '0) || gnt_q[gnt_id_q]);

endmodule
